dma_addr_count_regs: RTL and testbench

//  Per-channel current/base address and word-count register file for the 8237-style DMA controller.

---
 rtl/dma_addr_count_regs_pkg.sv | 28 ++
 rtl/dma_addr_count_regs_chan.sv | 94 +++++++++
 rtl/dma_addr_count_regs.sv | 122 ++++++++++++
 tb/tb_dma_addr_count_regs.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_addr_count_regs_pkg.sv
// Shared types and register map for the DMA address/count register file.
// Optional autoinit reload is enabled by defining DMA_AUTOINIT_EN.
package dma_pkg;

  localparam int DMA_NUM_CH = 4;
  localparam int DMA_AW     = 16;

  localparam logic [3:0] ADDR_MODE  = 4'hB;
  localparam logic [3:0] ADDR_CLRFF = 4'hC;
  localparam logic [3:0] ADDR_MCLR  = 4'hD;

  typedef struct packed {
    logic autoinit;
    logic dec;
  } mode_t;

  typedef struct packed {
    logic [DMA_AW-1:0] base_addr;
    logic [DMA_AW-1:0] base_cnt;
    logic [DMA_AW-1:0] cur_addr;
    logic [DMA_AW-1:0] cur_cnt;
  } chan_regs_t;

  function automatic logic [7:0] sel_byte(input logic [DMA_AW-1:0] v, input logic hi);
    return hi ? v[DMA_AW-1:8] : v[7:0];
  endfunction

endpackage

// File: rtl/dma_addr_count_regs_chan.sv
// One DMA channel: base/current address and count, mode bits, step/reload arithmetic, carry detect.
// DMA_AUTOINIT_EN enables reload of current registers from base on a terminal-count step.
module dma_chan_regs
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mclr,
  input  logic              i_wr_addr,
  input  logic              i_wr_cnt,
  input  logic              i_wr_hi,
  input  logic              i_mode_wr,
  input  logic              i_step,
  input  logic [7:0]        i_data,
  output logic [DMA_AW-1:0] o_cur_addr,
  output logic [DMA_AW-1:0] o_cur_cnt,
  output logic              o_tc,
  output logic              o_carry
);

  localparam logic [DMA_AW-1:0] ONE = DMA_AW'(1);

  chan_regs_t        r_regs;
  mode_t             r_mode;
  logic              w_reload;
  logic [DMA_AW-1:0] w_next_addr;
  logic [DMA_AW-1:0] w_next_cnt;

  assign o_tc       = (r_regs.cur_cnt == '0);
  assign o_cur_addr = r_regs.cur_addr;
  assign o_cur_cnt  = r_regs.cur_cnt;

  always_comb begin
`ifdef DMA_AUTOINIT_EN
    w_reload = o_tc & r_mode.autoinit;
`else
    w_reload = 1'b0;
`endif
    if (w_reload) begin
      w_next_addr = r_regs.base_addr;
      w_next_cnt  = r_regs.base_cnt;
    end else begin
      w_next_addr = r_mode.dec ? (r_regs.cur_addr - ONE) : (r_regs.cur_addr + ONE);
      w_next_cnt  = r_regs.cur_cnt - ONE;
    end
  end

  // Carry also covers a reload that changes the upper byte.
  assign o_carry = i_step && (w_next_addr[DMA_AW-1:8] != r_regs.cur_addr[DMA_AW-1:8]);

`ifndef DMA_AUTOINIT_EN
  // Base registers and autoinit are still programmed, only the reload path is absent.
  logic w_unused_base;
  assign w_unused_base = ^{r_regs.base_addr, r_regs.base_cnt, r_mode.autoinit};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
      r_mode <= '0;
    end else if (i_mclr) begin
      r_regs <= '0;
      r_mode <= '0;
    end else begin
      if (i_mode_wr) begin
        r_mode.autoinit <= i_data[4];
        r_mode.dec      <= i_data[5];
      end
      if (i_wr_addr) begin
        if (i_wr_hi) begin
          r_regs.base_addr[DMA_AW-1:8] <= i_data;
          r_regs.cur_addr[DMA_AW-1:8]  <= i_data;
        end else begin
          r_regs.base_addr[7:0] <= i_data;
          r_regs.cur_addr[7:0]  <= i_data;
        end
      end
      if (i_wr_cnt) begin
        if (i_wr_hi) begin
          r_regs.base_cnt[DMA_AW-1:8] <= i_data;
          r_regs.cur_cnt[DMA_AW-1:8]  <= i_data;
        end else begin
          r_regs.base_cnt[7:0] <= i_data;
          r_regs.cur_cnt[7:0]  <= i_data;
        end
      end
      if (i_step) begin
        r_regs.cur_addr <= w_next_addr;
        r_regs.cur_cnt  <= w_next_cnt;
      end
    end
  end

endmodule

// File: rtl/dma_addr_count_regs.sv
// 8237-style per-channel address/count register file: CPU slave port, byte pointer, svc_ch select, carry flag.
// Define DMA_AUTOINIT_EN to enable autoinit reload at terminal count.
module dma_addr_count_regs
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH,
  parameter int AW     = DMA_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CS_N,
  input  logic          IOW_N,
  input  logic          IOR_N,
  input  logic [3:0]    A,
  input  logic [7:0]    DB_in,
  output logic [7:0]    DB_out,
  output logic          DB_oe,
  input  logic          HLDA,
  input  logic [1:0]    svc_ch,
  input  logic          step,
  input  logic          upper_ack,
  output logic [AW-1:0] addr_o,
  output logic          TC,
  output logic          carryPresent
);

  logic              r_ff;
  logic              r_iow_q;
  logic              r_rd_q;
  logic              r_carry;
  logic              w_port_en;
  logic              w_wr;
  logic              w_rd;
  logic              w_reg_hit;
  logic              w_mclr;
  logic              w_clrff;
  logic              w_mode_wr;
  logic              w_step_ok;
  logic [2:0]        w_sel;
  logic [3:0]        w_ch_tc;
  logic [3:0]        w_ch_carry;
  logic [DMA_AW-1:0] w_cur_addr [4];
  logic [DMA_AW-1:0] w_cur_cnt  [4];

  assign w_sel     = A[3:1];
  assign w_reg_hit = (32'(w_sel) < NUM_CH);
  assign w_port_en = !CS_N && !HLDA;
  // A held-low write strobe acts once, on the cycle it is first seen low.
  assign w_wr      = w_port_en && !IOW_N && r_iow_q;
  assign w_rd      = w_port_en && !IOR_N;
  assign w_mclr    = w_wr && (A == ADDR_MCLR);
  assign w_clrff   = w_wr && (A == ADDR_CLRFF);
  assign w_mode_wr = w_wr && (A == ADDR_MODE);
  assign w_step_ok = step && HLDA;

  for (genvar ch = 0; ch < 4; ch++) begin : g_ch
    if (ch < NUM_CH) begin : g_inst
      dma_chan_regs u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mclr     (w_mclr),
        .i_wr_addr  (w_wr && (w_sel == 3'(ch)) && !A[0]),
        .i_wr_cnt   (w_wr && (w_sel == 3'(ch)) && A[0]),
        .i_wr_hi    (r_ff),
        .i_mode_wr  (w_mode_wr && (DB_in[1:0] == 2'(ch))),
        .i_step     (w_step_ok && (svc_ch == 2'(ch))),
        .i_data     (DB_in),
        .o_cur_addr (w_cur_addr[ch]),
        .o_cur_cnt  (w_cur_cnt[ch]),
        .o_tc       (w_ch_tc[ch]),
        .o_carry    (w_ch_carry[ch])
      );
    end else begin : g_tie
      assign w_cur_addr[ch] = '0;
      assign w_cur_cnt[ch]  = '0;
      assign w_ch_tc[ch]    = 1'b0;
      assign w_ch_carry[ch] = 1'b0;
    end
  end

  always_comb begin
    DB_out = 8'h00;
    if (w_rd && w_reg_hit) begin
      DB_out = sel_byte(A[0] ? w_cur_cnt[w_sel[1:0]] : w_cur_addr[w_sel[1:0]], r_ff);
    end
  end

  assign DB_oe        = w_rd;
  assign addr_o       = AW'(w_cur_addr[svc_ch]);
  assign TC           = w_ch_tc[svc_ch];
  assign carryPresent = r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff    <= 1'b0;
      r_iow_q <= 1'b1;
      r_rd_q  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_iow_q <= IOW_N;
      r_rd_q  <= w_rd && w_reg_hit;
      if (w_mclr) begin
        r_ff    <= 1'b0;
        r_carry <= 1'b0;
      end else begin
        // Reads advance the pointer when the access ends so the byte stays stable while IOR_N is low.
        if (w_clrff)
          r_ff <= 1'b0;
        else if (w_wr && w_reg_hit)
          r_ff <= ~r_ff;
        else if (r_rd_q && !(w_rd && w_reg_hit))
          r_ff <= ~r_ff;

        if (|w_ch_carry)
          r_carry <= 1'b1;
        else if (upper_ack)
          r_carry <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_addr_count_regs.sv
// Randomized bench for dma_addr_count_regs against a behavioural register-file model.
// Honours DMA_AUTOINIT_EN in the model when the design is built with it.
module tb_dma_addr_count_regs;

  logic        clk;
  logic        rst_n;
  logic        CS_N, IOW_N, IOR_N;
  logic [3:0]  A;
  logic [7:0]  DB_in;
  logic [7:0]  DB_out;
  logic        DB_oe;
  logic        HLDA;
  logic [1:0]  svc_ch;
  logic        step;
  logic        upper_ack;
  logic [15:0] addr_o;
  logic        TC;
  logic        carryPresent;

  dma_addr_count_regs dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CS_N         (CS_N),
    .IOW_N        (IOW_N),
    .IOR_N        (IOR_N),
    .A            (A),
    .DB_in        (DB_in),
    .DB_out       (DB_out),
    .DB_oe        (DB_oe),
    .HLDA         (HLDA),
    .svc_ch       (svc_ch),
    .step         (step),
    .upper_ack    (upper_ack),
    .addr_o       (addr_o),
    .TC           (TC),
    .carryPresent (carryPresent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_base_addr [4];
  int m_base_cnt  [4];
  int m_cur_addr  [4];
  int m_cur_cnt   [4];
  bit m_ai        [4];
  bit m_dec       [4];
  bit m_ff;
  bit m_carry;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_base_addr[i] = 0; m_base_cnt[i] = 0;
      m_cur_addr[i]  = 0; m_cur_cnt[i]  = 0;
      m_ai[i] = 0; m_dec[i] = 0;
    end
    m_ff = 0;
    m_carry = 0;
  endfunction

  function automatic int put_byte(input int v, input int d, input bit hi);
    return hi ? ((d << 8) | (v & 'hFF)) : ((v & 'hFF00) | d);
  endfunction

  function automatic void model_wr(input int a, input int d);
    int ch;
    if (a < 8) begin
      ch = a / 2;
      if (a % 2 == 0) begin
        m_base_addr[ch] = put_byte(m_base_addr[ch], d, m_ff);
        m_cur_addr[ch]  = put_byte(m_cur_addr[ch], d, m_ff);
      end else begin
        m_base_cnt[ch] = put_byte(m_base_cnt[ch], d, m_ff);
        m_cur_cnt[ch]  = put_byte(m_cur_cnt[ch], d, m_ff);
      end
      m_ff = !m_ff;
    end else if (a == 'hB) begin
      m_ai[d % 4]  = ((d >> 4) & 1) != 0;
      m_dec[d % 4] = ((d >> 5) & 1) != 0;
    end else if (a == 'hC) begin
      m_ff = 0;
    end else if (a == 'hD) begin
      model_reset();
    end
  endfunction

  function automatic int model_rd(input int a);
    int v;
    if (a >= 8) return 0;
    v = (a % 2 == 0) ? m_cur_addr[a / 2] : m_cur_cnt[a / 2];
    return m_ff ? (v >> 8) & 'hFF : v & 'hFF;
  endfunction

  function automatic void model_step(input bit st, input bit ack, input int c);
    int old;
    bit set = 0;
    bit reloaded = 0;
    if (st) begin
      old = m_cur_addr[c];
`ifdef DMA_AUTOINIT_EN
      if (m_cur_cnt[c] == 0 && m_ai[c]) begin
        m_cur_addr[c] = m_base_addr[c];
        m_cur_cnt[c]  = m_base_cnt[c];
        reloaded = 1;
      end
`endif
      if (!reloaded) begin
        m_cur_addr[c] = (m_cur_addr[c] + (m_dec[c] ? 65535 : 1)) % 65536;
        m_cur_cnt[c]  = (m_cur_cnt[c] + 65535) % 65536;
      end
      set = (old / 256) != (m_cur_addr[c] / 256);
    end
    if (set) m_carry = 1;
    else if (ack) m_carry = 0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_addr"},  addr_o, m_cur_addr[svc_ch]);
    chk({tag, "_tc"},    TC, (m_cur_cnt[svc_ch] == 0));
    chk({tag, "_carry"}, carryPresent, m_carry);
  endtask

  task automatic cpu_wr(input int a, input int d, input int hold);
    bit hl;
    @(negedge clk);
    hl = HLDA;
    CS_N = 0; A = a[3:0]; DB_in = d[7:0]; IOW_N = 0;
    repeat (hold) @(negedge clk);
    IOW_N = 1; CS_N = 1;
    @(negedge clk);
    if (!hl) model_wr(a, d);
  endtask

  task automatic cpu_rd(input int a, input string tag);
    int exp;
    @(negedge clk);
    CS_N = 0; A = a[3:0]; IOR_N = 0;
    @(negedge clk);
    exp = HLDA ? 0 : model_rd(a);
    chk({tag, "_data"}, DB_out, exp);
    chk({tag, "_oe"}, DB_oe, !HLDA);
    IOR_N = 1; CS_N = 1;
    @(negedge clk);
    if (!HLDA && a < 8) m_ff = !m_ff;
  endtask

  task automatic step_cyc(input bit st, input bit ack, input string tag);
    @(negedge clk);
    step = st; upper_ack = ack;
    @(negedge clk);
    step = 0; upper_ack = 0;
    model_step(st && HLDA, ack, svc_ch);
    check_outputs(tag);
  endtask

  task automatic prog_ch(input int ch, input int addr, input int cnt);
    cpu_wr('hC, 0, 1);
    cpu_wr(2 * ch, addr & 'hFF, 1);
    cpu_wr(2 * ch, addr >> 8, 1);
    cpu_wr(2 * ch + 1, cnt & 'hFF, 1);
    cpu_wr(2 * ch + 1, cnt >> 8, 1);
  endtask

  initial begin
    int op, a, d;
    rst_n = 0; CS_N = 1; IOW_N = 1; IOR_N = 1; A = 0; DB_in = 0;
    HLDA = 0; svc_ch = 0; step = 0; upper_ack = 0;
    model_reset();
    #22;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    chk("rst_addr", addr_o, 0);
    chk("rst_tc", TC, 1);
    chk("rst_carry", carryPresent, 0);
    chk("rst_oe", DB_oe, 0);
    chk("rst_dbout", DB_out, 0);

    // Program ch1 and read it back in byte-pointer order.
    prog_ch(1, 'h12FE, 'h0002);
    cpu_wr('hB, 'h01, 1);
    cpu_wr('hC, 0, 1);
    cpu_rd(2, "rb_alo"); cpu_rd(2, "rb_ahi");
    cpu_rd(3, "rb_clo"); cpu_rd(3, "rb_chi");

    HLDA = 1; svc_ch = 1;
    step_cyc(1, 0, "s1");
    chk("s1_const", addr_o, 16'h12FF);
    chk("s1_tc0", TC, 0);
    step_cyc(1, 0, "s2");
    chk("s2_const", addr_o, 16'h1300);
    chk("s2_carry", carryPresent, 1);
    chk("s2_tc1", TC, 1);
    step_cyc(0, 1, "ack");
    chk("ack_clear", carryPresent, 0);
    step_cyc(1, 0, "s3");
    HLDA = 0;
    cpu_wr('hC, 0, 1);
    cpu_rd(3, "wrap_clo"); cpu_rd(3, "wrap_chi");
    chk("wrap_model", m_cur_cnt[1], 'hFFFF);

    // Step-carry and upper_ack together: set wins.
    prog_ch(0, 'h20FF, 'h0010);
    HLDA = 1; svc_ch = 0;
    step_cyc(1, 1, "setwins");
    chk("setwins_const", carryPresent, 1);
    step_cyc(0, 1, "ack2");

    // Decrement mode on ch2.
    HLDA = 0;
    cpu_wr('hB, 'h22, 1);
    prog_ch(2, 'h0100, 'h0005);
    HLDA = 1; svc_ch = 2;
    step_cyc(1, 0, "dec1");
    chk("dec1_const", addr_o, 16'h00FF);
    chk("dec1_carry", carryPresent, 1);
    step_cyc(0, 1, "dec_ack");
    HLDA = 0;
    prog_ch(2, 'h0000, 'h0005);
    HLDA = 1;
    step_cyc(1, 0, "decwrap");
    chk("decwrap_const", addr_o, 16'hFFFF);

    // Autoinit on ch3 at terminal count.
    HLDA = 0;
    cpu_wr('hB, 'h13, 1);
    prog_ch(3, 'h4000, 'h0000);
    HLDA = 1; svc_ch = 3;
    step_cyc(1, 0, "ai");
`ifdef DMA_AUTOINIT_EN
    chk("ai_const", addr_o, 16'h4000);
`else
    chk("ai_const", addr_o, 16'h4001);
`endif

    // CPU port ignored while HLDA=1; a held strobe counts once.
    cpu_wr(4, 'h55, 1);
    cpu_rd(4, "hlda_rd");
    HLDA = 0;
    cpu_wr('hC, 0, 1);
    cpu_rd(4, "hlda_lo"); cpu_rd(4, "hlda_hi");
    cpu_wr('hC, 0, 1);
    cpu_wr(0, 'hAA, 3);
    cpu_wr(0, 'hBB, 1);
    cpu_rd(0, "hold_lo"); cpu_rd(0, "hold_hi");
    chk("hold_model", m_cur_addr[0], 'hBBAA);

    for (int it = 0; it < 300; it++) begin
      svc_ch = 2'($urandom_range(0, 3));
      op = $urandom_range(0, 5);
      if (op == 0 || op == 1) begin
        HLDA = ($urandom_range(0, 7) == 0);
        a = $urandom_range(0, 15);
        if (a == 'hD && $urandom_range(0, 9) != 0) a = 'hC;
        d = $urandom_range(0, 255);
        cpu_wr(a, d, $urandom_range(1, 2));
        check_outputs("rnd_wr");
      end else if (op == 2) begin
        HLDA = ($urandom_range(0, 7) == 0);
        cpu_rd($urandom_range(0, 15), "rnd_rd");
      end else begin
        HLDA = ($urandom_range(0, 5) != 0);
        step_cyc(1'($urandom_range(0, 1) | (op != 5)), 1'($urandom_range(0, 1)), "rnd_st");
      end
    end

    // Asynchronous reset mid-transfer.
    HLDA = 1; svc_ch = 0;
    @(negedge clk);
    step = 1;
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst_addr", addr_o, 0);
    chk("arst_carry", carryPresent, 0);
    chk("arst_oe", DB_oe, 0);
    chk("arst_tc", TC, 1);
    @(negedge clk);
    step = 0; rst_n = 1;

    // Master clear.
    HLDA = 0;
    cpu_wr('hB, 'h31, 1);
    prog_ch(1, 'hABCD, 'h1234);
    HLDA = 1; svc_ch = 1;
    step_cyc(1, 0, "pre_mc");
    HLDA = 0;
    cpu_wr('hD, 0, 1);
    chk("mc_model_check", m_cur_addr[1], 0);
    check_outputs("mc");
    cpu_rd(2, "mc_alo"); cpu_rd(3, "mc_cnt");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
